// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult_hs shift-add multiplier.
// Optional build macro used by the top: SEQ_MULT_EARLY_TERM_EN.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Two's-complement negate when neg is set; callers size-cast the result.
  function automatic logic [31:0] cond_neg(input logic [31:0] val, input logic neg);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Operand magnitude former: WIDTH-bit value plus signed flag in,
// WIDTH+1-bit magnitude (room for -2^(WIDTH-1)) and sign bit out.
module seq_mult_abs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_signed,
  output logic [WIDTH:0]   o_mag,
  output logic             o_neg
);

  logic [WIDTH:0] w_ext;

  always_comb begin
    o_neg = i_signed & i_val[WIDTH-1];
    w_ext = {o_neg, i_val};
    o_mag = (WIDTH+1)'(cond_neg(32'(w_ext), o_neg));
  end

endmodule

// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// Build macro SEQ_MULT_EARLY_TERM_EN: leave CALC as soon as the multiplier runs out of set bits.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH:0]   r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic [PW-1:0]    r_product;

  logic [WIDTH:0]   w_mag_a;
  logic [WIDTH:0]   w_mag_b;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic             w_accept;
  logic             w_last;
  logic [PW-1:0]    w_acc_nxt;
  logic [WIDTH:0]   w_mplier_shr;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PW-1:0]    w_prod_nxt;

  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (
    .i_val    (a),
    .i_signed (signed_mode),
    .o_mag    (w_mag_a),
    .o_neg    (w_sgn_a)
  );

  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (
    .i_val    (b),
    .i_signed (signed_mode),
    .o_mag    (w_mag_b),
    .o_neg    (w_sgn_b)
  );

  always_comb begin
    w_acc_nxt    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_shr = r_mplier >> 1;
    w_cnt_nxt    = r_cnt - 1'b1;
    w_prod_nxt   = PW'(cond_neg(32'(w_acc_nxt), r_neg));
`ifdef SEQ_MULT_EARLY_TERM_EN
    w_last       = (w_cnt_nxt == '0) || (w_mplier_shr == '0);
`else
    w_last       = (w_cnt_nxt == '0);
`endif
  end

  // Handshake outputs decode from state only, so out_ready never reaches in_ready.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else if (w_accept) begin
      r_acc     <= '0;
      r_mcand   <= {{(PW-WIDTH-1){1'b0}}, w_mag_a};
      r_mplier  <= w_mag_b;
      r_cnt     <= CNT_W'(WIDTH);
      r_neg     <= w_sgn_a ^ w_sgn_b;
    end else if (r_state == CALC) begin
      r_acc     <= w_acc_nxt;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= w_mplier_shr;
      r_cnt     <= w_cnt_nxt;
      if (w_last) r_product <= w_prod_nxt;
    end
  end

  assign product = r_product;

endmodule
